// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with in-order response FIFO and redirect flush
// Ports:
//   clk, reset (async, active-low)
//   imem_req_valid/ready/addr   fetch request channel (addr word aligned)
//   imem_rsp_valid/data         in-order responses, no backpressure
//   redirect_valid/pc           taken-branch flush and refetch
//   out_valid/ready/pc/instr    head of the fetched-instruction FIFO toward IF/ID
//   occupancy                   entries currently held in the FIFO
module fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_W-1:0]          imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INSTR_W-1:0]         imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [CW-1:0]      inflight, discard, inflight_next, occ_next, discard_next;
    logic [CW:0]        total_next;
    logic [AW-1:0]      tag_wr, tag_rd, wr, rd;
    logic [ADDR_W-1:0]  tag_mem [DEPTH];
    logic [ADDR_W-1:0]  mem_pc [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic               fire, rsp, drop, push, pop, req_next;

    assign imem_req_addr = fetch_pc;
    assign out_valid = |occupancy;
    assign out_pc = out_valid ? mem_pc[rd] : '0;
    assign out_instr = out_valid ? mem_instr[rd] : '0;

    always_comb begin
        fire = imem_req_valid & imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored
        rsp = imem_rsp_valid & (|inflight);
        drop = rsp & (redirect_valid | (|discard));
        push = rsp & ~drop;
        pop = out_valid & out_ready;
        inflight_next = inflight + CW'(fire) - CW'(rsp);
        occ_next = redirect_valid ? '0 : occupancy + CW'(push) - CW'(pop);
        // On redirect every request still outstanding afterwards is wrong-path;
        // earlier discards are already part of that outstanding count
        discard_next = redirect_valid ? inflight_next : discard - CW'(rsp & (|discard));
        total_next = {1'b0, occ_next} + {1'b0, inflight_next};
        // Registering the credit test on next-state counts equals testing the
        // current counts next cycle, while letting reset force valid low
        req_next = total_next < (CW+1)'(DEPTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            imem_req_valid <= 1'b0;
            inflight <= '0;
            discard <= '0;
            occupancy <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            wr <= '0;
            rd <= '0;
        end else begin
            fetch_pc <= redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : fire ? fetch_pc + ADDR_W'(4) : fetch_pc;
            imem_req_valid <= req_next;
            inflight <= inflight_next;
            discard <= discard_next;
            occupancy <= occ_next;
            tag_wr <= tag_wr + AW'(fire);
            tag_rd <= tag_rd + AW'(rsp);
            wr <= wr + AW'(push);
            rd <= redirect_valid ? wr : rd + AW'(pop);
        end
    end

    // Storage needs no reset: pointers and counts decide what is visible
    always_ff @(posedge clk) begin
        if (fire) tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            mem_pc[wr] <= tag_mem[tag_rd];
            mem_instr[wr] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) imem_rsp_valid |-> |inflight);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a latency-configurable memory model
module tb_fetch_queue;
    localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid, out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    fetch_queue #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [63:0] addr; } pend_t;
    pend_t       pend[$];
    logic [95:0] exp_q[$];
    logic [95:0] mon_e;
    int          checks = 0, errors = 0;
    int          cyc = 0, k = 1, last_due = 0, fires = 0, fires_base = 0, d = 0;

    function automatic logic [31:0] mem_data(logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic void expect_pc(logic [63:0] pc);
        exp_q.push_back({pc, mem_data(pc)});
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: in-order, latency k cycles, at most one response per cycle
    initial forever begin
        @(negedge clk);
        if (reset && imem_req_valid && imem_req_ready) begin
            d = (cyc + k > last_due) ? cyc + k : last_due + 1;
            pend.push_back('{d, imem_req_addr});
            last_due = d;
            fires++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_data(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
        end
    end

    // Monitor: every accepted output entry must match the scoreboard head
    initial forever begin
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %h expected no entry", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc, mon_e[95:32]);
                chk("out_instr", 64'(out_instr), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_addr", imem_req_addr, RPC);

        // Streaming with k=1, including the address wrap from RESET_PC
        for (int i = 0; i < 8; i++) expect_pc(RPC + 64'(4 * i));
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            if (i == 0) begin
                chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
                chk("t1_addr", imem_req_addr, RPC);
                chk("t1_out_valid_c1", 64'(out_valid), 64'd0);
            end
            if (i == 1) chk("t1_out_valid_c2", 64'(out_valid), 64'd0);
            if (i == 2) chk("t1_out_valid_c3", 64'(out_valid), 64'd1);
        end
        step();
        imem_req_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t1_addr_held", imem_req_addr, 64'h18);
        chk("t1_req_valid_held", 64'(imem_req_valid), 64'd1);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: credit stops issue at DEPTH
        fires_base = fires;
        step();
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("t2_fires", 64'(fires - fires_base), 64'd4);
        chk("t2_occupancy", 64'(occupancy), 64'd4);
        chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t2_addr", imem_req_addr, 64'h28);
        chk("t2_head_pc", out_pc, 64'h18);
        for (int i = 0; i < 5; i++) expect_pc(64'h18 + 64'(4 * i));
        step();
        out_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        chk("t2_addr_end", imem_req_addr, 64'h2C);
        chk("t2_occupancy_end", 64'(occupancy), 64'd0);

        // Redirect with two slow requests in flight
        k = 3;
        step();
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        expect_pc(64'h100);
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t3_addr", imem_req_addr, 64'h100);
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        step();
        imem_req_ready = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        chk("t3_occupancy", 64'(occupancy), 64'd0);

        // Unaligned redirect target
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h103;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_addr", imem_req_addr, 64'h100);
        chk("t4_req_valid", 64'(imem_req_valid), 64'd1);

        // Redirect coinciding with a response, a pop and a fire
        k = 2;
        expect_pc(64'h100);
        expect_pc(64'h200);
        step();
        imem_req_ready = 1'b1;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_occupancy", 64'(occupancy), 64'd0);
        chk("t5_out_valid_next", 64'(out_valid), 64'd0);
        chk("t5_out_pc_zero", out_pc, 64'd0);
        chk("t5_addr", imem_req_addr, 64'h200);
        chk("t5_req_valid_next", 64'(imem_req_valid), 64'd1);
        step();
        imem_req_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-operation, then restart at RESET_PC
        k = 1;
        step();
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        pend.delete();
        last_due = 0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_occupancy", 64'(occupancy), 64'd0);
        chk("t6_out_pc", out_pc, 64'd0);
        chk("t6_addr", imem_req_addr, RPC);
        for (int i = 0; i < 3; i++) expect_pc(RPC + 64'(4 * i));
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        step();
        imem_req_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);
        chk("t6_addr_end", imem_req_addr, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
